// File: rtl/data_mem_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port data memory.
// Each transaction runs IDLE -> ACCESS -> DONE, one cycle per state.
module data_mem_arbiter #(
  parameter int WORDSIZE = 64,
  parameter int ADDR_W   = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_a,
  input  logic                req_b,
  input  logic                we_a,
  input  logic                we_b,
  input  logic [ADDR_W-1:0]   addr_a,
  input  logic [ADDR_W-1:0]   addr_b,
  input  logic [WORDSIZE-1:0] wdata_a,
  input  logic [WORDSIZE-1:0] wdata_b,
  output logic                done_a,
  output logic                done_b,
  output logic [WORDSIZE-1:0] rdata_a,
  output logic [WORDSIZE-1:0] rdata_b,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [WORDSIZE-1:0] mem_data_input,
  output logic                mem_write_enable,
  output logic                mem_read,
  input  logic [WORDSIZE-1:0] mem_data_output
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic                last_b_q, last_b_d;
  logic                win_b_q, win_b_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [WORDSIZE-1:0] wdata_q, wdata_d;
  logic [WORDSIZE-1:0] rdata_a_q, rdata_a_d;
  logic [WORDSIZE-1:0] rdata_b_q, rdata_b_d;
  logic                done_a_q, done_a_d;
  logic                done_b_q, done_b_d;

  logic grant;
  logic pick_b;

  // B wins alone, or on a tie when A was served last
  always_comb begin
    grant  = (state_q == IDLE) & (req_a | req_b);
    pick_b = req_b & (~req_a | ~last_b_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (grant) state_d = ACCESS;
      ACCESS:  state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_addr         = '0;
    mem_data_input   = '0;
    mem_write_enable = 1'b0;
    mem_read         = 1'b0;
    if (state_q == ACCESS) begin
      mem_addr         = addr_q;
      mem_data_input   = wdata_q;
      mem_write_enable = we_q;
      mem_read         = ~we_q;
    end
  end

  always_comb begin
    last_b_d  = last_b_q;
    win_b_d   = win_b_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_a_d = rdata_a_q;
    rdata_b_d = rdata_b_q;
    done_a_d  = 1'b0;
    done_b_d  = 1'b0;
    if (grant) begin
      last_b_d = pick_b;
      win_b_d  = pick_b;
      we_d     = pick_b ? we_b    : we_a;
      addr_d   = pick_b ? addr_b  : addr_a;
      wdata_d  = pick_b ? wdata_b : wdata_a;
    end
    if (state_q == ACCESS) begin
      done_a_d = ~win_b_q;
      done_b_d = win_b_q;
      if (!we_q) begin
        if (win_b_q) rdata_b_d = mem_data_output;
        else         rdata_a_d = mem_data_output;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_b_q  <= 1'b1;
      win_b_q   <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_a_q <= '0;
      rdata_b_q <= '0;
      done_a_q  <= 1'b0;
      done_b_q  <= 1'b0;
    end else begin
      last_b_q  <= last_b_d;
      win_b_q   <= win_b_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_a_q <= rdata_a_d;
      rdata_b_q <= rdata_b_d;
      done_a_q  <= done_a_d;
      done_b_q  <= done_b_d;
    end
  end

  assign done_a  = done_a_q;
  assign done_b  = done_b_q;
  assign rdata_a = rdata_a_q;
  assign rdata_b = rdata_b_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: directed scenarios plus random traffic
// checked against a transaction-level model.
module tb_data_mem_arbiter;

  localparam int W = 64;
  localparam int A = 5;

  logic         clk = 1'b0;
  logic         reset;
  logic         req_a, req_b;
  logic         we_a, we_b;
  logic [A-1:0] addr_a, addr_b;
  logic [W-1:0] wdata_a, wdata_b;
  logic         done_a, done_b;
  logic [W-1:0] rdata_a, rdata_b;
  logic [A-1:0] mem_addr;
  logic [W-1:0] mem_data_input;
  logic         mem_write_enable;
  logic         mem_read;
  logic [W-1:0] mem_data_output;

  data_mem_arbiter #(.WORDSIZE(W), .ADDR_W(A)) dut (
    .clk              (clk),
    .reset            (reset),
    .req_a            (req_a),
    .req_b            (req_b),
    .we_a             (we_a),
    .we_b             (we_b),
    .addr_a           (addr_a),
    .addr_b           (addr_b),
    .wdata_a          (wdata_a),
    .wdata_b          (wdata_b),
    .done_a           (done_a),
    .done_b           (done_b),
    .rdata_a          (rdata_a),
    .rdata_b          (rdata_b),
    .mem_addr         (mem_addr),
    .mem_data_input   (mem_data_input),
    .mem_write_enable (mem_write_enable),
    .mem_read         (mem_read),
    .mem_data_output  (mem_data_output)
  );

  always #5 clk = ~clk;

  logic [W-1:0] mem [32];
  assign mem_data_output = mem[mem_addr];
  always @(posedge clk)
    if (mem_write_enable) mem[mem_addr] <= mem_data_input;

  int n_chk = 0;
  int n_err = 0;

  task automatic check(string tag, logic [W-1:0] got,
                       logic [W-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Model: a grant at edge g means ACCESS after g, DONE after g+1,
  // and the next grant is possible at edge g+3.
  int           e = 0;
  int           g = -100;
  logic         m_lastb = 1'b1;
  logic         m_wb = 1'b0;
  logic         m_we = 1'b0;
  logic [A-1:0] m_addr = '0;
  logic [W-1:0] m_wd = '0;
  logic [W-1:0] m_rd [2];
  logic [W-1:0] ref_mem [32];

  task automatic tick();
    int d;
    logic acc, dn;
    @(posedge clk);
    e++;
    if (e - g == 1 && m_we) ref_mem[m_addr] = m_wd;
    if (!reset && e - g == 1 && !m_we) m_rd[m_wb] = ref_mem[m_addr];
    if (reset) begin
      g       = -100;
      m_lastb = 1'b1;
      m_rd[0] = '0;
      m_rd[1] = '0;
    end else if (e - g >= 3 && (req_a || req_b)) begin
      m_wb    = req_b && (!req_a || !m_lastb);
      m_lastb = m_wb;
      m_we    = m_wb ? we_b : we_a;
      m_addr  = m_wb ? addr_b : addr_a;
      m_wd    = m_wb ? wdata_b : wdata_a;
      g       = e;
    end
    #1;
    d   = e - g;
    acc = (d == 0);
    dn  = (d == 1);
    check("mem_we", W'(mem_write_enable), W'(acc && m_we));
    check("mem_rd", W'(mem_read), W'(acc && !m_we));
    check("mem_addr", W'(mem_addr), acc ? W'(m_addr) : '0);
    check("mem_din", mem_data_input, acc ? m_wd : '0);
    check("done_a", W'(done_a), W'(dn && !m_wb));
    check("done_b", W'(done_b), W'(dn && m_wb));
    check("rdata_a", rdata_a, m_rd[0]);
    check("rdata_b", rdata_b, m_rd[1]);
  endtask

  task automatic quiet();
    req_a = 0; req_b = 0; we_a = 0; we_b = 0;
    addr_a = '0; addr_b = '0; wdata_a = '0; wdata_b = '0;
  endtask

  int na, nb;
  logic [1:0] order [$];

  initial begin
    for (int i = 0; i < 32; i++) begin
      mem[i]     = {$urandom, $urandom};
      ref_mem[i] = mem[i];
    end
    m_rd[0] = '0;
    m_rd[1] = '0;
    quiet();
    reset = 1;
    #1;
    tick();
    tick();
    check("rst_done_a", W'(done_a), '0);
    reset = 0;
    tick();

    // write 0xAA to address 3 from A
    req_a = 1; we_a = 1; addr_a = 3; wdata_a = 64'hAA;
    tick();
    check("wr_we", W'(mem_write_enable), 1);
    check("wr_addr", W'(mem_addr), 3);
    quiet();
    tick();
    check("wr_done_a", W'(done_a), 1);
    check("wr_done_b", W'(done_b), 0);
    check("wr_we_off", W'(mem_write_enable), 0);
    tick();

    // read it back from B
    req_b = 1; we_b = 0; addr_b = 3;
    tick();
    check("rd_rd", W'(mem_read), 1);
    quiet();
    tick();
    check("rd_done_b", W'(done_b), 1);
    check("rd_data_b", rdata_b, 64'hAA);
    check("rd_data_a", rdata_a, 0);
    tick();

    // continuous tie alternates A, B, A, B
    reset = 1;
    req_a = 1; req_b = 1;
    addr_a = 1; addr_b = 2;
    tick();
    reset = 0;
    na = 0; nb = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done_a && done_b) check("rr_both", 1, 0);
      if (done_a) begin na++; order.push_back(2'd0); end
      if (done_b) begin nb++; order.push_back(2'd1); end
    end
    check("rr_na", W'(na), 2);
    check("rr_nb", W'(nb), 2);
    for (int i = 0; i < order.size(); i++)
      check("rr_order", W'(order[i]), W'(i % 2));
    quiet();
    tick(); tick(); tick();

    // one-cycle request pulse, read addr 7
    req_a = 1; we_a = 0; addr_a = 7;
    tick();
    quiet();
    tick();
    check("pulse_done", W'(done_a), 1);
    check("pulse_data", rdata_a, ref_mem[7]);
    tick();

    // reset during ACCESS of a write
    req_a = 1; we_a = 1; addr_a = 5; wdata_a = 64'h55;
    tick();
    quiet();
    reset = 1;
    tick();
    check("abort_we", W'(mem_write_enable), 0);
    check("abort_done", W'({done_a, done_b}), 0);
    reset = 0;
    tick();
    check("abort_idle", W'(done_a), 0);

    // address change in ACCESS is ignored
    req_a = 1; we_a = 0; addr_a = 4;
    tick();
    addr_a = 9;
    #2;
    check("hold_addr", W'(mem_addr), 4);
    quiet();
    tick();
    tick();

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      reset   = ($urandom_range(0, 63) == 0);
      req_a   = $urandom_range(0, 2) != 0;
      req_b   = $urandom_range(0, 2) != 0;
      we_a    = $urandom_range(0, 1);
      we_b    = $urandom_range(0, 1);
      addr_a  = A'($urandom);
      addr_b  = A'($urandom);
      wdata_a = {$urandom, $urandom};
      wdata_b = {$urandom, $urandom};
      tick();
      if (done_a && done_b) check("rnd_both_done", 1, 0);
      if (mem_write_enable && mem_read) check("rnd_both_strb", 1, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/data_mem_arbiter.md
DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

Interface
REQ-001 The module SHALL have parameter WORDSIZE, default 64, data word width in bits.
REQ-002 The module SHALL have parameter ADDR_W, default 5, memory address width in bits.
REQ-003 The port clk SHALL be an input, 1 bit wide: the single clock; all state updates on its rising edge.
REQ-004 The port reset SHALL be an input, 1 bit wide: synchronous, active-high reset.
REQ-005 The ports req_a and req_b SHALL be inputs, 1 bit each: access request from requester A or B.
REQ-006 The ports we_a and we_b SHALL be inputs, 1 bit each: 1 = write, 0 = read.
REQ-007 The ports addr_a and addr_b SHALL be inputs, ADDR_W bits each: target address.
REQ-008 The ports wdata_a and wdata_b SHALL be inputs, WORDSIZE bits each: write data.
REQ-009 The ports done_a and done_b SHALL be outputs, 1 bit each: one-cycle completion pulse.
REQ-010 The ports rdata_a and rdata_b SHALL be outputs, WORDSIZE bits each: registered read result.
REQ-011 The port mem_addr SHALL be an output, ADDR_W bits: address to the data memory.
REQ-012 The port mem_data_input SHALL be an output, WORDSIZE bits: write data to the data memory.
REQ-013 The port mem_write_enable SHALL be an output, 1 bit: data memory write strobe.
REQ-014 The port mem_read SHALL be an output, 1 bit: data memory read enable.
REQ-015 The port mem_data_output SHALL be an input, WORDSIZE bits: combinational read data from the data memory.

Function
REQ-016 The controller SHALL implement a three-state FSM with states IDLE, ACCESS and DONE.
REQ-017 In IDLE, at a rising edge with at least one req high, the controller SHALL latch the winner's we, addr and wdata plus the winner identity, then move to ACCESS.
REQ-018 With both requests high in IDLE, the grant SHALL go to the requester not served last; last_served SHALL update on every grant.
REQ-019 In ACCESS, the controller SHALL drive mem_addr and mem_data_input from the latched values, together with mem_write_enable = latched we and mem_read = not latched we.
REQ-020 Outside ACCESS, mem_write_enable and mem_read SHALL be 0, and mem_addr and mem_data_input SHALL be 0.
REQ-021 At the edge ending ACCESS on a read, the controller SHALL capture mem_data_output into the winner's rdata register; a write SHALL leave both rdata registers unchanged.
REQ-022 ACCESS SHALL always last exactly one cycle and then move to DONE.
REQ-023 In DONE, the controller SHALL assert done for the winner only, for exactly one cycle, then return to IDLE.
REQ-024 Latency: with a request sampled at edge N, memory access SHALL occur in cycle N..N+1 and done SHALL be high in cycle N+1..N+2, giving a minimum of 3 cycles per transaction.
REQ-025 Requests SHALL be sampled only in IDLE; req, we, addr and wdata changes in ACCESS or DONE SHALL be ignored.
REQ-026 A req dropped mid-transaction SHALL NOT abort the transaction, and done SHALL still pulse.
REQ-027 A req still high in the IDLE following DONE SHALL start a new transaction, subject to round-robin; a losing requester SHALL be served no later than the next transaction.
REQ-028 rdata_x SHALL hold its value until that requester's next read completes.
REQ-029 done_a and done_b SHALL never be high in the same cycle, and mem_write_enable and mem_read SHALL never be high in the same cycle.

Reset
REQ-030 While reset is high at a rising edge, the FSM SHALL enter IDLE and last_served SHALL become B, so that A wins the first tie.
REQ-031 Reset SHALL clear done_a, done_b, rdata_a, rdata_b and all latched request fields to 0.
REQ-032 Reset asserted in ACCESS or DONE SHALL abort the transaction with no done pulse, and memory strobes SHALL be 0 from the following cycle.
REQ-033 Reset SHALL take priority over all other inputs.

Verification
REQ-034 The bench SHALL cover: reset, then req_a=1, we_a=1, addr_a=3, wdata_a=0xAA -> mem_write_enable=1 with mem_addr=3 exactly one cycle, then done_a one cycle later, done_b=0.
REQ-035 The bench SHALL cover: after a write of 0xAA at address 3, req_b=1, we_b=0, addr_b=3 -> mem_read=1 one cycle, done_b pulse, rdata_b=0xAA, rdata_a unchanged.
REQ-036 The bench SHALL cover: after reset, req_a=req_b=1 held continuously -> grants alternate A, B, A, B with done pulses every 3 cycles, never both in one cycle.
REQ-037 The bench SHALL cover: req_a pulsed for one IDLE cycle only, read addr 7 -> transaction completes, done_a pulses, rdata_a = memory[7].
REQ-038 The bench SHALL cover: reset asserted during ACCESS of a write -> no done pulse, FSM in IDLE, all outputs 0 next cycle.
REQ-039 The bench SHALL cover: addr_a changed during ACCESS from 4 to 9 -> mem_addr stays 4 for the whole ACCESS cycle.
